serial_subtractor: RTL and testbench
====================================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and result width in bits; legal range is 2..32.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin a subtraction, sampled on the rising edge of clk.
REQ-005 The block SHALL have port a, input, WIDTH bits: the minuend, latched when start is accepted.
REQ-006 The block SHALL have port b, input, WIDTH bits: the subtrahend, latched when start is accepted.
REQ-007 The block SHALL have port bin, input, 1 bit: the initial borrow-in, latched when start is accepted.
REQ-008 The block SHALL have port diff, output, WIDTH bits: the result a - b - bin, valid while done is high and held afterwards.
REQ-009 The block SHALL have port bout, output, 1 bit: the final borrow-out, 1 exactly when a < b + bin (unsigned).
REQ-010 The block SHALL have port busy, output, 1 bit: high while in the SHIFT state.
REQ-011 The block SHALL have port done, output, 1 bit: a one-cycle pulse marking that the result is valid.

Function
REQ-012 The FSM SHALL have three states, IDLE, SHIFT and DONE, and SHALL take the following transitions.
- IDLE -> SHIFT on start.
- SHIFT -> DONE after exactly WIDTH shift cycles.
- DONE -> SHIFT if start is high, otherwise DONE -> IDLE.
REQ-013 The block SHALL accept start only in IDLE or DONE; on acceptance it SHALL latch a, b and bin, clear the bit counter and load the internal borrow with bin.
REQ-014 Each SHIFT cycle SHALL process one bit, LSB first.
- d = ai ^ bi ^ br.
- br_next = (~ai & bi) | (~(ai ^ bi) & br).
- d is shifted into the MSB of the result register.
REQ-015 The bit counter SHALL be $clog2(WIDTH+1) bits wide; the last shift cycle is the one in which the counter equals WIDTH-1.
REQ-016 Latency: if start is accepted at edge k, busy SHALL be high for edges k+1..k+WIDTH and done SHALL be high for the single cycle following edge k+WIDTH.
REQ-017 diff and bout SHALL update only at the transition into DONE and SHALL hold until the next transition into DONE.
REQ-018 start while busy is high SHALL be ignored, with no effect on the operands or the counter.
REQ-019 start high in the DONE cycle SHALL begin a new operation back-to-back; done still pulses for that cycle, and busy rises on the next cycle.
REQ-020 Edge cases with WIDTH=8:
- a == b with bin = 0 SHALL give diff 0 and bout 0.
- a = 0, b = 0, bin = 1 SHALL give diff 0xFF and bout 1.

Reset
REQ-021 While rst_n is low, the block SHALL force state IDLE, diff = 0, bout = 0, busy = 0, done = 0, and clear the counter and operand registers.
REQ-022 A reset mid-operation SHALL abort the operation with no done pulse; after release, the block SHALL accept start on the first edge.

Configuration
REQ-023 When macro SERIAL_SUB_OVF_EN is defined, the block SHALL add an output ovf (1 bit, reset 0), updated with diff: ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), giving signed two's-complement overflow.
REQ-024 When SERIAL_SUB_OVF_EN is undefined, the ovf port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-025 Package serial_sub_pkg SHALL hold the FSM state typedef (IDLE, SHIFT, DONE) and the default width constant.
REQ-026 One-bit subtraction SHALL be a sub-module full_subtractor with ports x, y, bi, d and bo, instantiated once.

Verification
REQ-027 With a=0x05, b=0x03, bin=0: after start, busy SHALL be high for 8 cycles, then done SHALL pulse with diff=0x02 and bout=0.
REQ-028 With a=0x03, b=0x05, bin=0: the result SHALL be diff=0xFE, bout=1; with a=0x00, b=0x00, bin=1: the result SHALL be diff=0xFF, bout=1.
REQ-029 With a=0xFF, b=0x01 and start held high across DONE, followed by a=0x10, b=0x10: the results SHALL be 0xFE/0 then 0x00/0, with two done pulses 9 cycles apart.
REQ-030 Pulsing start with new operands at shift cycle 3: the new start SHALL be ignored and the result SHALL come from the original operands.
REQ-031 Asserting rst_n low at shift cycle 4: all outputs SHALL read 0 and no done pulse SHALL occur; a subsequent start of 0x09 - 0x04 SHALL give diff 0x05.
REQ-032 With SERIAL_SUB_OVF_EN defined: 0x80 - 0x01 SHALL give diff 0x7F, ovf 1; 0x10 - 0x01 SHALL give diff 0x0F, ovf 0.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// The FSM state encoding and the default operand width live here.
package serial_sub_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Signed overflow of a - b: operand signs differ and the result sign departs from a.
  function automatic logic sub_ovf(input logic a_msb, input logic b_msb, input logic d_msb);
    return (a_msb != b_msb) && (d_msb != a_msb);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = x - y - bi, with borrow-out bo.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  always_comb begin
    d  = x ^ y ^ bi;
    bo = (~x & y) | (~(x ^ y) & bi);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor computing a - b - bin one bit per cycle, LSB first.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             busy,
  output logic             done
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d;
  logic             bout_q, bout_d;
  logic             fs_d, fs_bo;
  logic             accept;

`ifdef SERIAL_SUB_OVF_EN
  // Operand sign bits are kept aside because the operand registers shift away.
  logic a_msb_q, a_msb_d;
  logic b_msb_q, b_msb_d;
  logic ovf_q, ovf_d;
`endif

  full_subtractor u_fs (
    .x  (a_q[0]),
    .y  (b_q[0]),
    .bi (br_q),
    .d  (fs_d),
    .bo (fs_bo)
  );

  assign accept = start && ((state_q == IDLE) || (state_q == DONE));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    diff_d  = diff_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    bout_d  = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    ovf_d   = ovf_q;
`endif

    case (state_q)
      SHIFT: begin
        a_d   = {1'b0, a_q[WIDTH-1:1]};
        b_d   = {1'b0, b_q[WIDTH-1:1]};
        br_d  = fs_bo;
        res_d = {fs_d, res_q[WIDTH-1:1]};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_CNT) begin
          state_d = DONE;
          diff_d  = res_d;
          bout_d  = fs_bo;
`ifdef SERIAL_SUB_OVF_EN
          ovf_d   = sub_ovf(a_msb_q, b_msb_q, fs_d);
`endif
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Acceptance overrides the IDLE/DONE defaults above, giving back-to-back starts.
    if (accept) begin
      state_d = SHIFT;
      a_d     = a;
      b_d     = b;
      br_d    = bin;
      cnt_d   = '0;
      res_d   = '0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_d = a[WIDTH-1];
      b_msb_d = b[WIDTH-1];
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      diff_q  <= diff_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      bout_q  <= bout_d;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign diff = diff_q;
  assign bout = bout_q;
  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);
`ifdef SERIAL_SUB_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor at WIDTH=8.
// Overflow checks are compiled in when SERIAL_SUB_OVF_EN is defined.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       bin = 1'b0;
  logic [7:0] diff;
  logic       bout;
  logic       busy;
  logic       done;
`ifdef SERIAL_SUB_OVF_EN
  logic       ovf;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .diff  (diff),
    .bout  (bout),
    .busy  (busy),
    .done  (done)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // One full operation: start pulse, count busy cycles, check result and one-cycle done.
  task automatic do_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                       input logic bi, input logic [7:0] exp_d, input logic exp_b);
    int busy_n;
    int wait_n;
    @(negedge clk);
    a = av; b = bv; bin = bi; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    busy_n = 0;
    wait_n = 0;
    while (!done && wait_n < 40) begin
      if (busy) busy_n++;
      @(negedge clk);
      wait_n++;
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_busy_cycles"}, 32'(busy_n), 32'd8);
    check({tag, "_diff"}, 32'(diff), 32'(exp_d));
    check({tag, "_bout"}, 32'(bout), 32'(exp_b));
    $display("op %s: %02h - %02h - %0d -> diff=%02h bout=%0d", tag, av, bv, bi, diff, bout);
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_diff_hold"}, 32'(diff), 32'(exp_d));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int t;
    int wait_n;
    int busy_n;
    int done_seen;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_bout", 32'(bout), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;

    do_op("sub_05_03", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0);
    do_op("sub_03_05", 8'h03, 8'h05, 1'b0, 8'hFE, 1'b1);
    do_op("sub_00_00_b1", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1);
    do_op("sub_eq", 8'h5A, 8'h5A, 1'b0, 8'h00, 1'b0);
    do_op("sub_00_01_b1", 8'h00, 8'h01, 1'b1, 8'hFE, 1'b1);
    do_op("sub_80_7F_b1", 8'h80, 8'h7F, 1'b1, 8'h00, 1'b0);
`ifdef SERIAL_SUB_OVF_EN
    do_op("ovf_80_01", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0);
    check("ovf_80_01_ovf", 32'(ovf), 32'd1);
    do_op("ovf_10_01", 8'h10, 8'h01, 1'b0, 8'h0F, 1'b0);
    check("ovf_10_01_ovf", 32'(ovf), 32'd0);
`endif

    // Back-to-back: start held high through the first DONE cycle
    @(negedge clk);
    a = 8'hFF; b = 8'h01; bin = 1'b0; start = 1'b1;
    wait_n = 0;
    while (!done && wait_n < 40) begin
      @(negedge clk);
      wait_n++;
    end
    check("b2b_done1", 32'(done), 32'd1);
    check("b2b_diff1", 32'(diff), 32'hFE);
    check("b2b_bout1", 32'(bout), 32'd0);
    $display("op b2b_1: ff - 01 -> diff=%02h bout=%0d", diff, bout);
    a = 8'h10; b = 8'h10;
    @(negedge clk);
    start = 1'b0;
    check("b2b_busy_rise", 32'(busy), 32'd1);
    t = 0;
    while (!done && t < 40) begin
      @(negedge clk);
      t++;
    end
    check("b2b_done2", 32'(done), 32'd1);
    check("b2b_gap", 32'(t + 1), 32'd9);
    check("b2b_diff2", 32'(diff), 32'h00);
    check("b2b_bout2", 32'(bout), 32'd0);
    $display("op b2b_2: 10 - 10 -> diff=%02h bout=%0d gap=%0d", diff, bout, t + 1);

    // Start during SHIFT is ignored
    @(negedge clk);
    a = 8'h0A; b = 8'h03; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    a = 8'hFF; b = 8'h00; bin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_n = 0;
    while (!done && wait_n < 40) begin
      @(negedge clk);
      wait_n++;
    end
    check("ign_done", 32'(done), 32'd1);
    check("ign_latency", 32'(wait_n), 32'd5);
    check("ign_diff", 32'(diff), 32'h07);
    check("ign_bout", 32'(bout), 32'd0);
    $display("op ignore_start: 0a - 03 -> diff=%02h bout=%0d", diff, bout);

    // Reset mid-operation
    @(negedge clk);
    a = 8'h0A; b = 8'h03; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_diff", 32'(diff), 32'd0);
    check("mid_rst_bout", 32'(bout), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    done_seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    a = 8'h09; b = 8'h04; bin = 1'b0; start = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("post_rst_busy", 32'(busy), 32'd1);
    busy_n = 0;
    wait_n = 0;
    while (!done && wait_n < 40) begin
      if (busy) busy_n++;
      @(negedge clk);
      wait_n++;
    end
    check("mid_rst_no_done", 32'(done_seen), 32'd0);
    check("post_rst_done", 32'(done), 32'd1);
    check("post_rst_busy_cycles", 32'(busy_n), 32'd8);
    check("post_rst_diff", 32'(diff), 32'h05);
    check("post_rst_bout", 32'(bout), 32'd0);
    $display("op post_reset: 09 - 04 -> diff=%02h bout=%0d", diff, bout);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
